// File: rtl/stdin_hex_parser_pkg.sv
// stdin_hex_pkg: shared types and ASCII constants for the stdin hex parser
package stdin_hex_pkg;
    typedef enum logic [2:0] {IDLE, DIGITS, EMIT, WAIT_SEP, SKIP} state_e;
    typedef enum logic [1:0] {CLS_HEX, CLS_SEP, CLS_BAD} byte_cls_e;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_HT = 8'h09;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
endpackage

// File: rtl/stdin_hex_parser_if.sv
// stdio: valid/ready word channel between a producer and the stdin FIFO
interface stdio;
    logic        val;
    logic        rdy;
    logic [15:0] data;
    modport out    (output val, data, input rdy);
    modport in     (input val, data, output rdy);
    modport master (output val, data, input rdy);
    modport slave  (input val, data, output rdy);
endinterface

// File: rtl/stdin_hex_parser_decode.sv
// ascii_hex_decode: classifies an ASCII byte as hex digit, separator or bad, and yields its nibble
module ascii_hex_decode
    import stdin_hex_pkg::*;
(
    input  logic [7:0] data_i,
    output byte_cls_e  cls_o,
    output logic [3:0] nib_o
);
    logic is_dig, is_alpha, is_sep;
    assign is_dig   = data_i >= 8'h30 && data_i <= 8'h39;
    assign is_alpha = (data_i >= 8'h41 && data_i <= 8'h46) || (data_i >= 8'h61 && data_i <= 8'h66);
    assign is_sep   = data_i == ASCII_SP || data_i == ASCII_HT || data_i == ASCII_CR || data_i == ASCII_LF;
    assign cls_o    = (is_dig || is_alpha) ? CLS_HEX : (is_sep ? CLS_SEP : CLS_BAD);
    assign nib_o    = is_dig ? data_i[3:0] : (is_alpha ? data_i[3:0] + 4'd9 : 4'd0);
endmodule

// File: rtl/stdin_hex_parser.sv
// stdin_hex_parser: assembles four-hex-digit tokens from a byte stream into 16-bit words
module stdin_hex_parser
    import stdin_hex_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rx_val_i,
    output logic             rx_rdy_o,
    input  logic [7:0]       rx_data_i,
    stdio.out                stdout,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o
);
    state_e           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q;
    byte_cls_e        cls;
    logic [3:0]       nib;
    logic             accept;

    ascii_hex_decode u_dec (.data_i(rx_data_i), .cls_o(cls), .nib_o(nib));

    assign rx_rdy_o    = state_q != EMIT;
    assign accept      = rx_val_i && rx_rdy_o;
    assign stdout.val  = state_q == EMIT;
    assign stdout.data = acc_q;
    assign err_o       = err_q;
    assign err_cnt_o   = err_cnt_q;

    // token FSM: digit accumulation, word hand-off and malformed-token recovery
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                if (cls == CLS_HEX) begin
                    acc_d   = {acc_q[11:0], nib};
                    cnt_d   = 2'd1;
                    state_d = DIGITS;
                end else if (cls == CLS_BAD) begin
                    err_d   = 1'b1;
                    state_d = SKIP;
                end
            end
            DIGITS: if (accept) begin
                if (cls == CLS_HEX) begin
                    acc_d   = {acc_q[11:0], nib};
                    cnt_d   = cnt_q + 2'd1;
                    state_d = cnt_q == 2'd3 ? EMIT : DIGITS;
                end else begin
                    err_d   = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = cls == CLS_SEP ? IDLE : SKIP;
                end
            end
            EMIT: if (stdout.rdy) begin
                cnt_d   = 2'd0;
                state_d = WAIT_SEP;
            end
            WAIT_SEP: if (accept) begin
                err_d   = cls != CLS_SEP;
                state_d = cls == CLS_SEP ? IDLE : SKIP;
            end
            SKIP: if (accept && cls == CLS_SEP) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state, accumulator and saturating error counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (err_d && err_cnt_q != {ERR_W{1'b1}}) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_stdin_hex_parser.sv
// tb_stdin_hex_parser: scoreboard bench for the hex parser and its byte decoder
module tb_stdin_hex_parser;
    import stdin_hex_pkg::*;
    localparam int ERR_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx_val = 1'b0;
    logic             rx_rdy;
    logic [7:0]       rx_data = 8'h00;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic [7:0]       dec_in = 8'h00;
    byte_cls_e        dec_cls;
    logic [3:0]       dec_nib;

    int checks = 0;
    int failures = 0;
    int err_pulses = 0;
    int val_cycles = 0;
    logic [15:0] exp_q[$];

    stdio out_if ();

    stdin_hex_parser #(.ERR_W(ERR_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rx_val_i(rx_val), .rx_rdy_o(rx_rdy),
        .rx_data_i(rx_data), .stdout(out_if), .err_o(err), .err_cnt_o(err_cnt)
    );

    ascii_hex_decode u_dec (.data_i(dec_in), .cls_o(dec_cls), .nib_o(dec_nib));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on each output handshake, tallies pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_if.val) val_cycles++;
            if (err) err_pulses++;
            if (out_if.val && out_if.rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%04h expected none", out_if.data);
                end else begin
                    check("word", {16'h0, out_if.data}, {16'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_val  = 1'b1;
        rx_data = b;
        while (!rx_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("rx_rdy_timeout", 32'(rx_rdy), 32'd1);
        @(negedge clk);
        rx_val = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_val", 32'(out_if.val), 32'd0);
        check("rst_data", 32'(out_if.data), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rx_rdy", 32'(rx_rdy), 32'd1);
    endtask

    initial begin
        int eb, vb;
        logic [3:0] en;
        byte_cls_e ec;
        out_if.rdy = 1'b1;
        for (int c = 0; c < 256; c++) begin
            dec_in = 8'(c);
            #1;
            en = 4'd0;
            ec = CLS_BAD;
            if (c >= 48 && c <= 57) begin ec = CLS_HEX; en = 4'(c - 48); end
            if (c >= 65 && c <= 70) begin ec = CLS_HEX; en = 4'(c - 55); end
            if (c >= 97 && c <= 102) begin ec = CLS_HEX; en = 4'(c - 87); end
            if (c == 32 || c == 9 || c == 13 || c == 10) ec = CLS_SEP;
            check($sformatf("dec_cls_%02h", c), 32'(dec_cls), 32'(ec));
            if (ec == CLS_HEX) check($sformatf("dec_nib_%02h", c), 32'(dec_nib), 32'(en));
        end

        do_reset();
        eb = err_pulses; vb = val_cycles;
        exp_q.push_back(16'h1A2F);
        send_str("1A2f\n");
        drain("t1");
        check("t1_val_cycles", 32'(val_cycles - vb), 32'd1);
        check("t1_err_cnt", 32'(err_cnt), 32'd0);

        do_reset();
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'hFFFF);
        out_if.rdy = 1'b0;
        send_str("0000");
        for (int i = 0; i < 5; i++) begin
            check("t2_stall_val", 32'(out_if.val), 32'd1);
            check("t2_stall_data", 32'(out_if.data), 32'h0000);
            check("t2_stall_rx_rdy", 32'(rx_rdy), 32'd0);
            @(negedge clk);
        end
        out_if.rdy = 1'b1;
        send_str(" FFFF\r\n");
        drain("t2");

        do_reset();
        eb = err_pulses; vb = val_cycles;
        send_str("12 \n");
        drain("t3");
        check("t3_no_word", 32'(val_cycles - vb), 32'd0);
        check("t3_err_pulses", 32'(err_pulses - eb), 32'd1);
        check("t3_err_cnt", 32'(err_cnt), 32'd1);

        do_reset();
        eb = err_pulses;
        exp_q.push_back(16'hBEEF);
        send_str("12G4 BEEF\n");
        drain("t4");
        check("t4_err_pulses", 32'(err_pulses - eb), 32'd1);
        check("t4_err_cnt", 32'(err_cnt), 32'd1);

        do_reset();
        eb = err_pulses;
        exp_q.push_back(16'hABCD);
        exp_q.push_back(16'h0001);
        send_str("ABCDE\n");
        check("t5_err_cnt", 32'(err_cnt), 32'd1);
        send_str("0001\n");
        drain("t5");
        check("t5_err_pulses", 32'(err_pulses - eb), 32'd1);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_str("x\n");
            check($sformatf("sat_%0d", i), 32'(err_cnt), i < 3 ? 32'(i + 1) : 32'd3);
        end

        do_reset();
        send_str("12");
        rst_n = 1'b0;
        #3;
        check("midrst_val", 32'(out_if.val), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(16'h3456);
        send_str("3456\n");
        drain("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
